vga_layer_compositor: RTL and testbench

VGA_LAYER_COMPOSITOR -- requirements
Module: vga_layer_compositor

---
 rtl/vga_layer_compositor.sv | 173 +++++++++++++++++
 tb/tb_vga_layer_compositor.sv | 377 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_layer_compositor.sv
// VGA layer compositor: 800x525 raster timing with a PIX_DIV clock divider.
// Three rectangular objects (player 1, player 2, stage) are snapshotted once
// per frame. Each pixel is classified into a layer code by priority, and the
// code is registered together with sync, blanking and the pixel coordinates.
module vga_layer_compositor #(
    parameter int PIX_DIV = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [63:0] p1VGA,
    input  logic [63:0] p2VGA,
    input  logic [63:0] stageVGA,
    output logic        hsync,
    output logic        vsync,
    output logic        video_on,
    output logic [1:0]  layer,
    output logic [9:0]  pix_x,
    output logic [9:0]  pix_y,
    output logic        frame_start
);

    localparam logic [1:0] DIV_LAST = 2'(PIX_DIV - 1);
    localparam logic [9:0] H_LAST   = 10'd799;
    localparam logic [9:0] V_LAST   = 10'd524;
    localparam logic [9:0] H_VIS    = 10'd640;
    localparam logic [9:0] V_VIS    = 10'd480;
    localparam logic [9:0] HS_START = 10'd656;
    localparam logic [9:0] HS_END   = 10'd751;
    localparam logic [9:0] VS_START = 10'd490;
    localparam logic [9:0] VS_END   = 10'd491;

    // Rectangle hit test. The end coordinates are formed at 17 bits so that
    // x+w and y+h cannot wrap. An empty rectangle never hits.
    function automatic logic obj_hit(input logic [63:0] obj,
                                     input logic [9:0]  h,
                                     input logic [9:0]  v);
        logic [16:0] x_end;
        logic [16:0] y_end;
        logic        in_x;
        logic        in_y;
        logic        non_empty;
        x_end     = {1'b0, obj[63:48]} + {1'b0, obj[31:16]};
        y_end     = {1'b0, obj[47:32]} + {1'b0, obj[15:0]};
        in_x      = ({6'd0, h} >= obj[63:48]) && ({7'd0, h} < x_end);
        in_y      = ({6'd0, v} >= obj[47:32]) && ({7'd0, v} < y_end);
        non_empty = (obj[31:16] != 16'd0) && (obj[15:0] != 16'd0);
        obj_hit   = non_empty && in_x && in_y;
    endfunction

    logic [1:0]  div_r;
    logic [9:0]  hc_r;
    logic [9:0]  vc_r;
    logic [63:0] p1_shadow_r;
    logic [63:0] p2_shadow_r;
    logic [63:0] stage_shadow_r;
    logic        frame_start_r;
    logic [1:0]  layer_r;
    logic [9:0]  pix_x_r;
    logic [9:0]  pix_y_r;
    logic        hsync_r;
    logic        vsync_r;
    logic        video_on_r;

    logic        pix_en_s;
    logic        frame_end_s;
    logic        visible_s;
    logic        hsync_next_s;
    logic        vsync_next_s;
    logic        hit_p1_s;
    logic        hit_p2_s;
    logic        hit_stage_s;
    logic [1:0]  layer_next_s;

    assign pix_en_s     = (div_r == DIV_LAST);
    assign frame_end_s  = (hc_r == H_LAST) && (vc_r == V_LAST);
    assign visible_s    = (hc_r < H_VIS) && (vc_r < V_VIS);
    assign hsync_next_s = !((hc_r >= HS_START) && (hc_r <= HS_END));
    assign vsync_next_s = !((vc_r >= VS_START) && (vc_r <= VS_END));
    assign hit_p1_s     = obj_hit(p1_shadow_r, hc_r, vc_r);
    assign hit_p2_s     = obj_hit(p2_shadow_r, hc_r, vc_r);
    assign hit_stage_s  = obj_hit(stage_shadow_r, hc_r, vc_r);

    // Layer priority: P1 over P2 over stage; blank outside the visible area
    always_comb begin
        layer_next_s = 2'd0;
        if (!visible_s) begin
            layer_next_s = 2'd0;
        end else if (hit_p1_s) begin
            layer_next_s = 2'd3;
        end else if (hit_p2_s) begin
            layer_next_s = 2'd2;
        end else if (hit_stage_s) begin
            layer_next_s = 2'd1;
        end else begin
            layer_next_s = 2'd0;
        end
    end

    // Pixel-rate divider: pix_en_s is high for one clock in every PIX_DIV
    always_ff @(posedge clock) begin
        if (reset) begin
            div_r <= 2'd0;
        end else if (pix_en_s) begin
            div_r <= 2'd0;
        end else begin
            div_r <= div_r + 2'd1;
        end
    end

    // Raster position: hc wraps at 799, vc advances on each hc wrap and wraps at 524
    always_ff @(posedge clock) begin
        if (reset) begin
            hc_r <= 10'd0;
            vc_r <= 10'd0;
        end else if (pix_en_s) begin
            if (hc_r == H_LAST) begin
                hc_r <= 10'd0;
                if (vc_r == V_LAST) begin
                    vc_r <= 10'd0;
                end else begin
                    vc_r <= vc_r + 10'd1;
                end
            end else begin
                hc_r <= hc_r + 10'd1;
            end
        end
    end

    // Object snapshot at the last pixel of the frame, flagged by frame_start
    always_ff @(posedge clock) begin
        if (reset) begin
            p1_shadow_r    <= 64'd0;
            p2_shadow_r    <= 64'd0;
            stage_shadow_r <= 64'd0;
            frame_start_r  <= 1'b0;
        end else if (pix_en_s && frame_end_s) begin
            p1_shadow_r    <= p1VGA;
            p2_shadow_r    <= p2VGA;
            stage_shadow_r <= stageVGA;
            frame_start_r  <= 1'b1;
        end else begin
            frame_start_r  <= 1'b0;
        end
    end

    // Output stage: every output describes the same pixel and holds between pix_en
    always_ff @(posedge clock) begin
        if (reset) begin
            layer_r    <= 2'd0;
            pix_x_r    <= 10'd0;
            pix_y_r    <= 10'd0;
            hsync_r    <= 1'b1;
            vsync_r    <= 1'b1;
            video_on_r <= 1'b0;
        end else if (pix_en_s) begin
            layer_r    <= layer_next_s;
            pix_x_r    <= hc_r;
            pix_y_r    <= vc_r;
            hsync_r    <= hsync_next_s;
            vsync_r    <= vsync_next_s;
            video_on_r <= visible_s;
        end
    end

    assign hsync       = hsync_r;
    assign vsync       = vsync_r;
    assign video_on    = video_on_r;
    assign layer       = layer_r;
    assign pix_x       = pix_x_r;
    assign pix_y       = pix_y_r;
    assign frame_start = frame_start_r;

endmodule

// File: tb/tb_vga_layer_compositor.sv
// Directed bench for vga_layer_compositor (PIX_DIV=2). Walks through reset,
// frame 0 (timing, empty shadows), frame 1 (hit boundaries, priority, mid-frame
// input change), frame 2 (snapshot update, edge cases) and a mid-frame reset.
module tb_vga_layer_compositor;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [63:0] p1VGA = 64'd0;
    logic [63:0] p2VGA = 64'd0;
    logic [63:0] stageVGA = 64'd0;
    logic        hsync;
    logic        vsync;
    logic        video_on;
    logic [1:0]  layer;
    logic [9:0]  pix_x;
    logic [9:0]  pix_y;
    logic        frame_start;

    int tests_run    = 0;
    int tests_failed = 0;
    int cyc          = 0;
    bit stuck        = 1'b0;

    // Monitor measurements
    logic vs_prev      = 1'b1;
    int   vs_last_fall = -1;
    int   vs_period    = 0;
    int   vs_low_start = 0;
    int   vs_low_len   = 0;
    int   fs_count     = 0;
    int   fs_misalign  = 0;

    vga_layer_compositor #(.PIX_DIV(2)) dut (
        .clock(clock), .reset(reset),
        .p1VGA(p1VGA), .p2VGA(p2VGA), .stageVGA(stageVGA),
        .hsync(hsync), .vsync(vsync), .video_on(video_on),
        .layer(layer), .pix_x(pix_x), .pix_y(pix_y),
        .frame_start(frame_start)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    // Passive monitor: vsync period/low width and frame_start pulses
    always @(negedge clock) begin
        if (!vsync && vs_prev) begin
            if (vs_last_fall >= 0) vs_period = cyc - vs_last_fall;
            vs_last_fall = cyc;
            vs_low_start = cyc;
        end
        if (vsync && !vs_prev) vs_low_len = cyc - vs_low_start;
        vs_prev = vsync;
        if (frame_start) begin
            fs_count++;
            if (pix_x != 10'd799 || pix_y != 10'd524) fs_misalign++;
        end
    end

    function automatic logic [63:0] obj(input int x, input int y, input int w, input int h);
        return {16'(x), 16'(y), 16'(w), 16'(h)};
    endfunction

    // Wait (bounded) until the outputs describe pixel (x,y)
    task automatic goto_pixel(input int x, input int y);
        int n = 0;
        if (stuck) return;
        while (!(pix_x == 10'(x) && pix_y == 10'(y)) && n < 1700000) begin
            @(negedge clock);
            n++;
        end
        if (n >= 1700000) begin
            stuck = 1'b1;
            tests_run++;
            tests_failed++;
            $display("FAIL goto(%0d,%0d): pixel not reached, got pix_x=%0d pix_y=%0d", x, y, pix_x, pix_y);
        end
    endtask

    task automatic test_reset();
        p1VGA    = obj(352, 250, 133, 125);
        p2VGA    = obj(400, 100, 50, 50);
        stageVGA = obj(323, 20, 506, 200);
        reset    = 1'b1;
        repeat (3) @(posedge clock);
        @(negedge clock);
        tests_run++;
        if ({hsync, vsync, video_on, frame_start} !== 4'b1100) begin
            tests_failed++;
            $display("FAIL reset_ctrl: got hs/vs/von/fs=%b%b%b%b, want 1100", hsync, vsync, video_on, frame_start);
        end
        tests_run++;
        if (layer !== 2'd0 || pix_x !== 10'd0 || pix_y !== 10'd0) begin
            tests_failed++;
            $display("FAIL reset_data: got layer=%0d x=%0d y=%0d, want 0 0 0", layer, pix_x, pix_y);
        end
        reset = 1'b0;
        @(negedge clock);
        tests_run++;
        if (video_on !== 1'b0) begin
            tests_failed++;
            $display("FAIL first_edge: got video_on=%b, want 0 (no pix_en yet)", video_on);
        end
        @(negedge clock);
        tests_run++;
        if (video_on !== 1'b1 || pix_x !== 10'd0 || pix_y !== 10'd0 || hsync !== 1'b1 || layer !== 2'd0) begin
            tests_failed++;
            $display("FAIL first_pixel: got von=%b x=%0d y=%0d hs=%b layer=%0d, want 1 0 0 1 0",
                     video_on, pix_x, pix_y, hsync, layer);
        end
    endtask

    task automatic test_timing();
        int von = 0;
        int hlow = 0;
        int t0 = 0;
        int n = 0;
        int xs[6]  = '{639, 640, 655, 656, 751, 752};
        int ehs[6] = '{1, 1, 1, 0, 0, 1};
        int evo[6] = '{1, 0, 0, 0, 0, 0};
        goto_pixel(0, 10);
        for (int i = 0; i < 1600; i++) begin
            if (video_on) von++;
            if (!hsync) hlow++;
            @(negedge clock);
        end
        tests_run++;
        if (von !== 1280 || hlow !== 192) begin
            tests_failed++;
            $display("FAIL line_counts: got video_on=%0d hsync_low=%0d clocks, want 1280 192", von, hlow);
        end
        for (int i = 0; i < 6; i++) begin
            goto_pixel(xs[i], 11);
            tests_run++;
            if (hsync !== 1'(ehs[i]) || video_on !== 1'(evo[i])) begin
                tests_failed++;
                $display("FAIL sync_edge x=%0d: got hs=%b von=%b, want %0d %0d", xs[i], hsync, video_on, ehs[i], evo[i]);
            end
        end
        while (hsync && n < 4000) begin @(negedge clock); n++; end
        t0 = cyc;
        while (!hsync && n < 4000) begin @(negedge clock); n++; end
        while (hsync && n < 4000) begin @(negedge clock); n++; end
        tests_run++;
        if (n >= 4000 || cyc - t0 !== 1600) begin
            tests_failed++;
            $display("FAIL hsync_period: got %0d clocks, want 1600", cyc - t0);
        end
    endtask

    task automatic test_shadow_zero();
        int xs[3] = '{330, 420, 352};
        int ys[3] = '{30, 120, 250};
        for (int i = 0; i < 3; i++) begin
            goto_pixel(xs[i], ys[i]);
            tests_run++;
            if (layer !== 2'd0) begin
                tests_failed++;
                $display("FAIL shadow_zero (%0d,%0d): got layer=%0d, want 0", xs[i], ys[i], layer);
            end
        end
    endtask

    task automatic test_frame_start(input int exp_count);
        int n = 0;
        while (!frame_start && n < 900000) begin @(negedge clock); n++; end
        tests_run++;
        if (n >= 900000 || pix_x !== 10'd799 || pix_y !== 10'd524) begin
            tests_failed++;
            $display("FAIL frame_start_pos: got fs=%b x=%0d y=%0d, want pulse at 799 524", frame_start, pix_x, pix_y);
        end
        @(negedge clock);
        tests_run++;
        if (frame_start !== 1'b0 || fs_count !== exp_count || fs_misalign !== 0) begin
            tests_failed++;
            $display("FAIL frame_start_count: got fs=%b count=%0d misaligned=%0d, want 0 %0d 0",
                     frame_start, fs_count, fs_misalign, exp_count);
        end
    endtask

    task automatic test_priority_a();
        goto_pixel(330, 30);
        tests_run++;
        if (layer !== 2'd1) begin
            tests_failed++;
            $display("FAIL prio_stage (330,30): got layer=%0d, want 1", layer);
        end
    endtask

    task automatic test_input_change();
        goto_pixel(0, 100);
        p1VGA    = obj(10, 250, 133, 125);
        p2VGA    = obj(600, 200, 100, 20);
        stageVGA = obj(0, 0, 0, 525);
    endtask

    task automatic test_priority_b();
        goto_pixel(420, 120);
        tests_run++;
        if (layer !== 2'd2) begin
            tests_failed++;
            $display("FAIL prio_p2 (420,120): got layer=%0d, want 2", layer);
        end
    endtask

    task automatic test_hit_bounds_a();
        int xs[3] = '{351, 352, 485};
        int ex[3] = '{0, 3, 0};
        for (int i = 0; i < 3; i++) begin
            goto_pixel(xs[i], 250);
            tests_run++;
            if (layer !== 2'(ex[i])) begin
                tests_failed++;
                $display("FAIL hit_bound (%0d,250): got layer=%0d, want %0d", xs[i], layer, ex[i]);
            end
        end
    endtask

    task automatic test_snapshot_hold();
        int xs[2] = '{10, 352};
        int ex[2] = '{0, 3};
        for (int i = 0; i < 2; i++) begin
            goto_pixel(xs[i], 260);
            tests_run++;
            if (layer !== 2'(ex[i])) begin
                tests_failed++;
                $display("FAIL snapshot_hold (%0d,260): got layer=%0d, want %0d", xs[i], layer, ex[i]);
            end
        end
    endtask

    task automatic test_priority_c();
        goto_pixel(100, 300);
        tests_run++;
        if (layer !== 2'd0) begin
            tests_failed++;
            $display("FAIL prio_bg (100,300): got layer=%0d, want 0", layer);
        end
    endtask

    task automatic test_hit_bounds_b();
        int xs[2] = '{484, 352};
        int ys[2] = '{374, 375};
        int ex[2] = '{3, 0};
        for (int i = 0; i < 2; i++) begin
            goto_pixel(xs[i], ys[i]);
            tests_run++;
            if (layer !== 2'(ex[i])) begin
                tests_failed++;
                $display("FAIL hit_bound (%0d,%0d): got layer=%0d, want %0d", xs[i], ys[i], layer, ex[i]);
            end
        end
    endtask

    task automatic test_vsync_timing();
        goto_pixel(0, 489);
        tests_run++;
        if (vsync !== 1'b1) begin
            tests_failed++;
            $display("FAIL vsync_edge vc=489: got %b, want 1", vsync);
        end
        goto_pixel(0, 490);
        tests_run++;
        if (vsync !== 1'b0) begin
            tests_failed++;
            $display("FAIL vsync_edge vc=490: got %b, want 0", vsync);
        end
        goto_pixel(0, 493);
        tests_run++;
        if (vs_period !== 840000 || vs_low_len !== 3200) begin
            tests_failed++;
            $display("FAIL vsync_period: got period=%0d low=%0d, want 840000 3200", vs_period, vs_low_len);
        end
    endtask

    task automatic test_edge_cases();
        int n = 0;
        int n_stage = 0;
        int n_p2 = 0;
        int n_p2_out = 0;
        int n_p1 = 0;
        while (!(pix_x == 10'd0 && pix_y == 10'd250) && n < 500000) begin
            if (layer == 2'd1) n_stage++;
            if (layer == 2'd3) n_p1++;
            if (layer == 2'd2) begin
                n_p2++;
                if (pix_x < 10'd600 || pix_x > 10'd639) n_p2_out++;
            end
            @(negedge clock);
            n++;
        end
        tests_run++;
        if (n >= 500000 || n_p2 !== 1600 || n_p2_out !== 0) begin
            tests_failed++;
            $display("FAIL edge_x600_w100: got p2 samples=%0d outside=%0d, want 1600 0", n_p2, n_p2_out);
        end
        tests_run++;
        if (n_stage !== 0 || n_p1 !== 0) begin
            tests_failed++;
            $display("FAIL edge_w0: got stage samples=%0d p1 samples=%0d, want 0 0", n_stage, n_p1);
        end
    endtask

    task automatic test_snapshot_next();
        int xs[4] = '{10, 352, 142, 143};
        int ys[4] = '{260, 260, 270, 270};
        int ex[4] = '{3, 0, 3, 0};
        for (int i = 0; i < 4; i++) begin
            goto_pixel(xs[i], ys[i]);
            tests_run++;
            if (layer !== 2'(ex[i])) begin
                tests_failed++;
                $display("FAIL snapshot_next (%0d,%0d): got layer=%0d, want %0d", xs[i], ys[i], layer, ex[i]);
            end
        end
    endtask

    task automatic test_mid_frame_reset();
        int n = 0;
        int hits = 0;
        goto_pixel(0, 300);
        reset = 1'b1;
        @(negedge clock);
        tests_run++;
        if ({hsync, vsync, video_on, frame_start} !== 4'b1100 || layer !== 2'd0 ||
            pix_x !== 10'd0 || pix_y !== 10'd0) begin
            tests_failed++;
            $display("FAIL midreset_vals: got hs/vs/von/fs=%b%b%b%b layer=%0d x=%0d y=%0d, want 1100 0 0 0",
                     hsync, vsync, video_on, frame_start, layer, pix_x, pix_y);
        end
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        @(negedge clock);
        tests_run++;
        if (pix_x !== 10'd0 || pix_y !== 10'd0 || video_on !== 1'b1) begin
            tests_failed++;
            $display("FAIL midreset_restart: got x=%0d y=%0d von=%b, want 0 0 1", pix_x, pix_y, video_on);
        end
        while (!(pix_x == 10'd0 && pix_y == 10'd420) && n < 700000) begin
            if (layer != 2'd0) hits++;
            @(negedge clock);
            n++;
        end
        tests_run++;
        if (n >= 700000 || hits !== 0) begin
            tests_failed++;
            $display("FAIL midreset_no_hits: got %0d non-background samples, want 0", hits);
        end
    endtask

    initial begin
        test_reset();
        // frame 0: shadows still empty
        test_timing();
        test_shadow_zero();
        test_frame_start(1);
        // frame 1: first snapshot in effect
        test_priority_a();
        test_input_change();
        test_priority_b();
        test_hit_bounds_a();
        test_snapshot_hold();
        test_priority_c();
        test_hit_bounds_b();
        test_vsync_timing();
        test_frame_start(2);
        // frame 2: inputs changed during frame 1 now visible
        test_edge_cases();
        test_snapshot_next();
        test_mid_frame_reset();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
